spi_ram_ctrl: RTL and testbench
===============================

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8: address width; MEM_DEPTH = 2**ADDR_SIZE.
REQ-003 Parameter TX_HOLD, default 8: cycles tx_valid stays high per read, matching the SPI slave's 8-bit MISO shift.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 din  input  10  command word from SPI slave rx_data; din[9:8] opcode, din[7:0] payload.
REQ-007 rx_valid  input  1  din valid strobe from SPI slave.
REQ-008 dout  output  8  read data to SPI slave tx_data.
REQ-009 tx_valid  output  1  dout valid; drives SPI slave tx_valid.

Function
REQ-010 Block SHALL act only on a rx_valid rising edge: rx_valid=1 this cycle and 0 the previous cycle. A registered rx_valid_q SHALL provide the previous value.
REQ-011 A rx_valid level held high SHALL produce exactly one command.
REQ-012 Opcode 2'b00 (WR_ADDR): wr_addr SHALL load din[7:0] at the accepting edge.
REQ-013 Opcode 2'b01 (WR_DATA): mem[wr_addr] SHALL take din[7:0] at the accepting edge.
REQ-014 After WR_DATA, wr_addr SHALL increment by 1, wrapping from MEM_DEPTH-1 to 0.
REQ-015 Opcode 2'b10 (RD_ADDR): rd_addr SHALL load din[7:0]; dout and tx_valid SHALL be unaffected.
REQ-016 Opcode 2'b11 (RD_DATA): din[7:0] is don't-care.
REQ-017 On RD_DATA, dout SHALL take mem[rd_addr] at the accepting edge, and tx_valid SHALL be 1 from the next cycle.
REQ-018 Read latency: one clk from the RD_DATA accepting edge to tx_valid=1.
REQ-019 After RD_DATA, rd_addr SHALL increment by 1, wrapping from MEM_DEPTH-1 to 0.
REQ-020 FSM states: IDLE and TX.
REQ-021 IDLE -> TX on an accepted RD_DATA; the hold counter SHALL load TX_HOLD-1.
REQ-022 In TX the counter SHALL decrement each cycle; TX -> IDLE when the counter is 0.
REQ-023 tx_valid SHALL be 1 exactly in TX, for exactly TX_HOLD cycles.
REQ-024 dout SHALL be stable throughout TX.
REQ-025 dout SHALL hold its last value in IDLE.
REQ-026 WR_ADDR, WR_DATA and RD_ADDR accepted during TX SHALL execute normally without disturbing dout, tx_valid or the counter.
REQ-027 RD_DATA accepted during TX SHALL reload dout from mem[rd_addr] and reload the counter to TX_HOLD-1; tx_valid SHALL stay 1 with no gap.
REQ-028 WR_DATA and RD_DATA to the same address in one cycle cannot occur, since one command is accepted per edge.
REQ-029 Read of a never-written address SHALL return the array content (undefined); the bench SHALL write first.

Reset
REQ-030 While rst_n=0 at a clk edge: dout=8'h00, tx_valid=0, state=IDLE, counter=0, wr_addr=0, rd_addr=0, rx_valid_q=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-TX SHALL drop tx_valid on the next edge.
REQ-033 Reset SHALL take priority over any accepted command in the same cycle.
REQ-034 After reset release, a rx_valid already high SHALL count as a rising edge (rx_valid_q=0).

Structure
REQ-035 Shared package spi_ram_pkg SHALL hold the opcode constants (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), the FSM state encoding and the TX_HOLD default.
REQ-036 One sub-module, spram_core, SHALL hold the single-port array: one write port or one read per cycle, synchronous, no reset, inferable as block RAM.
REQ-037 Edge detect, address registers, FSM and hold counter SHALL live in spi_ram_ctrl.

Verification
REQ-038 Reset, then pulse WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA -> dout=0xA5 one cycle after the RD_DATA edge; tx_valid high exactly 8 cycles.
REQ-039 WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, then read from 0xFF twice -> 0x11 then 0x22 (wr_addr and rd_addr wrap to 0x00).
REQ-040 Hold rx_valid high 5 cycles with WR_DATA 0x3C at address 0x05, then read 0x06 -> address 0x06 unchanged; only one write occurred.
REQ-041 RD_DATA at 0x20 (0x77), then RD_DATA at 0x21 (0x88) on TX cycle 3 -> tx_valid continuous 3+8 cycles; dout changes 0x77->0x88 once.
REQ-042 RD_DATA, then assert rst_n=0 on TX cycle 4 -> tx_valid=0 and dout=0x00 the next cycle; subsequent RD_ADDR/RD_DATA works normally.
REQ-043 WR_DATA 0x5A issued during TX -> tx_valid and dout unaffected; later read returns 0x5A.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM controller: command opcodes, FSM encoding
// and the default number of cycles a read result is presented to the SPI slave.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int TX_HOLD_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } state_t;

endpackage

// File: rtl/spram_core.sv
// Single-port synchronous byte RAM: one write or one read per cycle, no reset,
// so synthesis can map it onto a block RAM.
module spram_core
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    // rdata only changes on a read, so it keeps the last read value while idle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between an SPI slave and a byte RAM: edge-detects rx_valid,
// keeps separate auto-incrementing write/read pointers and holds read data for TX_HOLD cycles.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = TX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    logic                 rx_valid_q;
    logic                 cmd_accept;
    logic [1:0]           opcode;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic                 ram_we;
    logic                 ram_re;
    logic [7:0]           ram_rdata;
    logic                 dout_clr;
    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;

    assign opcode     = din[9:8];
    assign payload    = din[7:0];
    // Reset wins over a command arriving in the same cycle
    assign cmd_accept = rst_n && rx_valid && !rx_valid_q;
    assign ram_we     = cmd_accept && (opcode == CMD_WR_DATA);
    assign ram_re     = cmd_accept && (opcode == CMD_RD_DATA);
    assign ram_addr   = ram_re ? rd_addr : wr_addr;

    spram_core #(
        .ADDR_SIZE(ADDR_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_core (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(payload),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (cmd_accept) begin
                case (opcode)
                    CMD_WR_ADDR: wr_addr <= ADDR_SIZE'(payload);
                    CMD_WR_DATA: wr_addr <= wr_addr + 1'b1;
                    CMD_RD_ADDR: rd_addr <= ADDR_SIZE'(payload);
                    CMD_RD_DATA: rd_addr <= rd_addr + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // The RAM output register has no reset, so dout is masked until the first read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dout_clr <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ram_re) begin
                dout_clr <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (ram_re) begin
                    state_nx = ST_TX;
                    cnt_nx   = CNT_W'(TX_HOLD - 1);
                end
            end
            ST_TX: begin
                if (ram_re) begin
                    cnt_nx = CNT_W'(TX_HOLD - 1);
                end else if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign tx_valid = (state == ST_TX);
    assign dout     = dout_clr ? 8'h00 : ram_rdata;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus random command
// streams compared against a command-level reference model of the RAM and pointers.
module tb_spi_ram_ctrl;

    localparam int TX_HOLD = 8;
    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    int n_checks;
    int n_fail;

    logic [7:0] m_mem [256];
    bit         m_written [256];
    int         m_wr;
    int         m_rd;
    logic [7:0] m_dout;
    logic       m_prev_rx;
    int         m_edge;
    int         m_last_rd;

    spi_ram_ctrl #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8),
        .TX_HOLD  (TX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    // A read result is on the wire for TX_HOLD cycles after its accepting edge
    function automatic logic exp_tx();
        return ((m_edge - 1 - m_last_rd) < TX_HOLD) ? 1'b1 : 1'b0;
    endfunction

    // One clock: the model consumes the command seen at the rising edge,
    // then control returns at the falling edge for checking and driving
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_prev_rx = 1'b0;
            m_wr      = 0;
            m_rd      = 0;
            m_dout    = 8'h00;
            m_last_rd = -1000;
        end else begin
            if (rx_valid && !m_prev_rx) begin
                case (din[9:8])
                    OP_WA: m_wr = int'(din[7:0]);
                    OP_WD: begin
                        m_mem[m_wr]     = din[7:0];
                        m_written[m_wr] = 1'b1;
                        m_wr            = (m_wr + 1) % 256;
                    end
                    OP_RA: m_rd = int'(din[7:0]);
                    default: begin
                        m_dout    = m_mem[m_rd];
                        m_rd      = (m_rd + 1) % 256;
                        m_last_rd = m_edge;
                    end
                endcase
            end
            m_prev_rx = rx_valid;
        end
        m_edge++;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data);
        din      = {op, data};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        din      = {OP_WA, 8'h40};
        rx_valid = 1'b1;
        idle(3);
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_dout: got %h expected 00", dout);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid);
        end
        // rx_valid already high at release must count as a fresh command
        rst_n = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        send(OP_WD, 8'h9C);
        send(OP_RA, 8'h40);
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'h9C) begin
            n_fail++;
            $display("[TB] FAIL reset_release_edge: got %h expected 9c", dout);
        end
        idle(10);
    endtask

    task automatic test_basic();
        int run;
        send(OP_WA, 8'h12);
        send(OP_WD, 8'hA5);
        send(OP_RA, 8'h12);
        din      = {OP_RD, 8'h00};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (dout !== 8'hA5 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL basic_latency: got dout=%h tx=%b expected a5 1", dout, tx_valid);
        end
        run = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid) run++;
            n_checks++;
            if (tx_valid !== exp_tx() || dout !== m_dout) begin
                n_fail++;
                $display("[TB] FAIL basic_cycle%0d: got tx=%b dout=%h expected %b %h",
                         i, tx_valid, dout, exp_tx(), m_dout);
            end
        end
        n_checks++;
        if (run != TX_HOLD) begin
            n_fail++;
            $display("[TB] FAIL basic_tx_len: got %0d expected %0d", run, TX_HOLD);
        end
    endtask

    task automatic test_wrap();
        send(OP_WA, 8'hFF);
        send(OP_WD, 8'h11);
        send(OP_WD, 8'h22);
        send(OP_RA, 8'hFF);
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'h11) begin
            n_fail++;
            $display("[TB] FAIL wrap_read_ff: got %h expected 11", dout);
        end
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'h22) begin
            n_fail++;
            $display("[TB] FAIL wrap_read_00: got %h expected 22", dout);
        end
        idle(10);
    endtask

    task automatic test_held_rx();
        send(OP_WA, 8'h06);
        send(OP_WD, 8'h99);
        send(OP_WA, 8'h05);
        din      = {OP_WD, 8'h3C};
        rx_valid = 1'b1;
        idle(5);
        rx_valid = 1'b0;
        tick();
        send(OP_RA, 8'h05);
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL held_write: got %h expected 3c", dout);
        end
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'h99) begin
            n_fail++;
            $display("[TB] FAIL held_single_write: got %h expected 99", dout);
        end
        idle(10);
    endtask

    task automatic test_back_to_back();
        int run;
        int changes;
        logic [7:0] prev;
        send(OP_WA, 8'h20);
        send(OP_WD, 8'h77);
        send(OP_WD, 8'h88);
        send(OP_RA, 8'h20);
        run     = 0;
        changes = 0;
        prev    = 8'h00;
        din     = {OP_RD, 8'h00};
        for (int i = 0; i < 15; i++) begin
            rx_valid = (i == 0 || i == 3);
            tick();
            if (tx_valid) run++;
            if (i == 0) prev = dout;
            else if (dout !== prev) begin
                changes++;
                prev = dout;
            end
            n_checks++;
            if (tx_valid !== exp_tx() || dout !== m_dout) begin
                n_fail++;
                $display("[TB] FAIL b2b_cycle%0d: got tx=%b dout=%h expected %b %h",
                         i, tx_valid, dout, exp_tx(), m_dout);
            end
        end
        rx_valid = 1'b0;
        n_checks++;
        if (run != 3 + TX_HOLD || changes != 1 || dout !== 8'h88) begin
            n_fail++;
            $display("[TB] FAIL b2b_summary: got run=%0d changes=%0d dout=%h expected 11 1 88",
                     run, changes, dout);
        end
    endtask

    task automatic test_reset_mid_tx();
        send(OP_RA, 8'h12);
        din      = {OP_RD, 8'h00};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        idle(3);
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midtx_reset: got tx=%b dout=%h expected 0 00", tx_valid, dout);
        end
        rst_n = 1'b1;
        tick();
        send(OP_RA, 8'h12);
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'hA5 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midtx_after_reset: got dout=%h tx=%b expected a5 1", dout, tx_valid);
        end
        idle(10);
    endtask

    task automatic test_write_during_tx();
        int run;
        send(OP_WA, 8'h30);
        send(OP_RA, 8'h12);
        din      = {OP_RD, 8'h00};
        rx_valid = 1'b1;
        run      = 0;
        for (int i = 0; i < 12; i++) begin
            rx_valid = (i == 0 || i == 2);
            if (i == 2) din = {OP_WD, 8'h5A};
            tick();
            if (tx_valid) run++;
            n_checks++;
            if (tx_valid !== exp_tx() || dout !== 8'hA5) begin
                n_fail++;
                $display("[TB] FAIL wr_in_tx_cycle%0d: got tx=%b dout=%h expected %b a5",
                         i, tx_valid, dout, exp_tx());
            end
        end
        rx_valid = 1'b0;
        n_checks++;
        if (run != TX_HOLD) begin
            n_fail++;
            $display("[TB] FAIL wr_in_tx_len: got %0d expected %0d", run, TX_HOLD);
        end
        send(OP_RA, 8'h30);
        send(OP_RD, 8'h00);
        n_checks++;
        if (dout !== 8'h5A) begin
            n_fail++;
            $display("[TB] FAIL wr_in_tx_readback: got %h expected 5a", dout);
        end
        idle(10);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] data;
        int hold;
        int gap;
        int tries;
        for (int c = 0; c < 200; c++) begin
            op   = 2'($urandom_range(0, 3));
            data = 8'($urandom_range(0, 255));
            if (op == OP_RD && !m_written[m_rd]) begin
                op    = OP_RA;
                tries = 0;
                while (!m_written[data] && tries < 1000) begin
                    data = 8'($urandom_range(0, 255));
                    tries++;
                end
                if (!m_written[data]) data = 8'h12;
            end
            if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
            din  = {op, data};
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 10);
            for (int i = 0; i < hold + gap; i++) begin
                rx_valid = (i < hold);
                tick();
                rst_n = 1'b1;
                n_checks++;
                if (tx_valid !== exp_tx() || dout !== m_dout) begin
                    n_fail++;
                    $display("[TB] FAIL random_cmd%0d_cycle%0d: got tx=%b dout=%h expected %b %h",
                             c, i, tx_valid, dout, exp_tx(), m_dout);
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_wr      = 0;
        m_rd      = 0;
        m_dout    = 8'h00;
        m_prev_rx = 1'b0;
        m_edge    = 0;
        m_last_rd = -1000;
        for (int i = 0; i < 256; i++) begin
            m_mem[i]     = 8'h00;
            m_written[i] = 1'b0;
        end
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_held_rx();
        test_back_to_back();
        test_reset_mid_tx();
        test_write_during_tx();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
